// File: rtl/rgmii_tx_frame.sv
// rgmii_tx_frame: sends header, divider byte and buffered payload as DDR nibbles with a trailing idle gap
module rgmii_tx_frame #(
   parameter int HDR_LEN = 24,
   parameter logic [7:0] PRE_BYTE = 8'h55,
   parameter logic [7:0] SFD_BYTE = 8'hD5,
   parameter int IFG_BYTES = 12,
   parameter int AW = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [AW-1:0] len,
   input  logic [7:0] div,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic busy,
   output logic done,
   output logic txclk,
   output logic txctl,
   output logic [3:0] txd
);
   typedef enum logic [2:0] {IDLE, HDR, DIV, DATA, GAP} state_t;
   localparam logic [AW-1:0] HDR_LAST = AW'(HDR_LEN - 1);
   localparam logic [AW-1:0] IFG_LAST = AW'(IFG_BYTES - 1);
   localparam logic [7:0] FIRST_BYTE = (HDR_LEN == 1) ? SFD_BYTE : PRE_BYTE;
   state_t state, state_n;
   logic [AW-1:0] cnt, cnt_n, len_q, rd_addr_n;
   logic [7:0] div_q, cur, cur_n;
   logic busy_n, done_n, txctl_n;
   logic [3:0] txd_n;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      cur_n = cur;
      txctl_n = txctl;
      txd_n = txd;
      rd_addr_n = rd_addr;
      done_n = 1'b0;
      busy_n = busy | start;
      if (txclk) begin
         // txclk falling: pick the next byte, drive its high nibble and frame valid
         cur_n = '0;
         case (state)
            IDLE: if (busy) begin
               state_n = HDR;
               cnt_n = '0;
               cur_n = FIRST_BYTE;
            end
            HDR: if (cnt == HDR_LAST) begin
               state_n = DIV;
               cur_n = div_q;
            end else begin
               cnt_n = cnt + 1'b1;
               cur_n = (cnt + 1'b1 == HDR_LAST) ? SFD_BYTE : PRE_BYTE;
            end
            DIV: begin
               cnt_n = '0;
               state_n = (len_q == '0) ? GAP : DATA;
               cur_n = (len_q == '0) ? 8'h00 : rd_data;
            end
            DATA: if (cnt == len_q - 1'b1) begin
               state_n = GAP;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
               cur_n = rd_data;
            end
            GAP: if (cnt == IFG_LAST) begin
               state_n = IDLE;
               done_n = 1'b1;
               busy_n = 1'b0;
            end else cnt_n = cnt + 1'b1;
            default: state_n = IDLE;
         endcase
         txctl_n = state_n inside {HDR, DIV, DATA};
         txd_n = cur_n[7:4];
      end else begin
         // txclk rising: low nibble, and prefetch the next payload byte
         txd_n = cur[3:0];
         rd_addr_n = (state == DIV && len_q != '0) ? '0 :
                     (state == DATA && cnt != len_q - 1'b1) ? cnt + 1'b1 : rd_addr;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         cur <= '0;
         len_q <= '0;
         div_q <= '0;
         txclk <= 1'b0;
         txctl <= 1'b0;
         txd <= '0;
         rd_addr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         cur <= cur_n;
         txclk <= ~txclk;
         txctl <= txctl_n;
         txd <= txd_n;
         rd_addr <= rd_addr_n;
         busy <= busy_n;
         done <= done_n;
         if (start && !busy) begin
            len_q <= len;
            div_q <= div;
         end
      end
   end
endmodule

// File: tb/tb_rgmii_tx_frame.sv
// tb_rgmii_tx_frame: directed frame vectors plus reset, busy-start and back-to-back corner cases
module tb_rgmii_tx_frame;
   logic clk, rst, start, busy, done, txclk, txctl;
   logic [12:0] len, rd_addr;
   logic [7:0] div, rd_data;
   logic [3:0] txd;
   logic [7:0] ram [8192];
   int n_chk = 0, n_fail = 0;

   rgmii_tx_frame dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .div(div),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .txclk(txclk), .txctl(txctl), .txd(txd)
   );

   assign rd_data = ram[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] l;
      logic [7:0] d;
      bit mid;
      int exp_ctl;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] d);
      if (idx < 23) return 8'h55;
      if (idx == 23) return 8'hD5;
      if (idx == 24) return d;
      return ram[idx - 25];
   endfunction

   // Starts a frame at a negedge and follows it up to the done sample
   task automatic run(input string tag, input logic [12:0] l, input logic [7:0] d,
                      input bit mid, input int exp_ctl, output int pre, output int gap);
      int ctl = 0, nd = 0, idx = 0, berr = 0, lat = 0, cyc = 0;
      logic [3:0] hi = 4'h0;
      logic [12:0] addr0;
      bit seen = 0, fin = 0;
      pre = 0;
      gap = 0;
      addr0 = rd_addr;
      start = 1'b1;
      len = l;
      div = d;
      @(negedge clk);
      start = 1'b0;
      len = 13'h1FFF;
      div = 8'h00;
      while (!fin && cyc < 400) begin
         cyc++;
         if (txctl) begin
            if (!seen) lat = cyc;
            seen = 1;
            ctl++;
            if (!txclk) hi = txd;
            else begin
               if ({hi, txd} !== exp_byte(idx, d)) berr++;
               idx++;
            end
         end else if (!seen) pre++;
         else if (!done) gap++;
         if (done) begin
            nd++;
            fin = 1;
            check({tag, " busy_at_done"}, busy, 0);
         end
         if (mid && cyc == 20) begin
            start = 1'b1;
            len = 13'd9;
            div = 8'h99;
         end else if (mid && cyc == 21) start = 1'b0;
         if (!fin) @(negedge clk);
      end
      check({tag, " done_seen"}, fin, 1);
      check({tag, " ctl_clk"}, ctl, exp_ctl);
      check({tag, " bytes"}, idx, 25 + l);
      check({tag, " byte_errs"}, berr, 0);
      check({tag, " gap_clk"}, gap, 24);
      check({tag, " latency_2or3"}, (lat == 2 || lat == 3), 1);
      check({tag, " rd_addr"}, rd_addr, (l == 0) ? addr0 : l - 1);
   endtask

   vec_t tbl[4];
   int pre, gap, pre2, gap2, bad, nd, nc;

   initial begin
      tbl[0] = '{l: 13'd4, d: 8'h3C, mid: 0, exp_ctl: 58};
      tbl[1] = '{l: 13'd0, d: 8'hFF, mid: 0, exp_ctl: 50};
      tbl[2] = '{l: 13'd4, d: 8'h3C, mid: 1, exp_ctl: 58};
      tbl[3] = '{l: 13'd3, d: 8'h00, mid: 0, exp_ctl: 56};
      for (int i = 0; i < 8192; i++) ram[i] = 8'(i * 7 + 1);
      ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;
      rst = 1'b1;
      start = 1'b0;
      len = '0;
      div = '0;
      repeat (3) @(negedge clk);
      check("rst txclk", txclk, 0);
      check("rst txctl", txctl, 0);
      check("rst txd", txd, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst rd_addr", rd_addr, 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         logic p;
         p = txclk;
         @(negedge clk);
         if (txclk === p || txctl !== 1'b0 || txd !== 4'h0 || busy !== 1'b0) bad++;
      end
      check("idle violations", bad, 0);

      for (int i = 0; i < 4; i++) begin
         run($sformatf("vec%0d", i), tbl[i].l, tbl[i].d, tbl[i].mid, tbl[i].exp_ctl, pre, gap);
         nd = 0;
         nc = 0;
         for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            nd += int'(done);
            nc += int'(txctl);
         end
         check($sformatf("vec%0d extra_done", i), nd, 0);
         check($sformatf("vec%0d extra_ctl", i), nc, 0);
      end

      // reset during payload byte 2
      start = 1'b1;
      len = 13'd4;
      div = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10 && !txctl; k++) @(negedge clk);
      check("rst_mid frame_started", txctl, 1);
      repeat (54) @(negedge clk);
      check("rst_mid in_byte2", {txctl, txd}, 5'h1C);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid txctl", txctl, 0);
      check("rst_mid txd", txd, 0);
      check("rst_mid busy", busy, 0);
      check("rst_mid txclk", txclk, 0);
      rst = 1'b0;
      nd = 0;
      nc = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         nd += int'(done);
         nc += int'(txctl);
      end
      check("rst_mid no_done", nd, 0);
      check("rst_mid no_ctl", nc, 0);
      run("after_rst", 13'd4, 8'h3C, 0, 58, pre, gap);

      // start on the clk right after done
      run("b2b_first", 13'd2, 8'h81, 0, 54, pre, gap);
      run("b2b_second", 13'd1, 8'h42, 0, 52, pre2, gap2);
      check("b2b low_before", (gap + 1 + pre2) >= 24, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
